// File: rtl/vending_pkg.sv
// Shared vending-machine definitions: coin value codes and the acceptor state encoding.
package vending_pkg;

    localparam logic [3:0] COIN_1  = 4'b0001;
    localparam logic [3:0] COIN_2  = 4'b0010;
    localparam logic [3:0] COIN_5  = 4'b0101;
    localparam logic [3:0] COIN_10 = 4'b1010;

    typedef enum logic [1:0] {
        ACC_IDLE    = 2'd0,
        ACC_SETTLE  = 2'd1,
        ACC_EMIT    = 2'd2,
        ACC_RELEASE = 2'd3
    } acc_state_t;

    function automatic logic is_one_hot(input logic [3:0] p);
        return (p != 4'b0000) && ((p & (p - 4'b0001)) == 4'b0000);
    endfunction

    // Slot index to coin value; non-single-slot patterns have no value.
    function automatic logic [3:0] coin_code(input logic [3:0] p);
        logic [3:0] code;
        case (p)
            4'b0001: code = COIN_1;
            4'b0010: code = COIN_2;
            4'b0100: code = COIN_5;
            4'b1000: code = COIN_10;
            default: code = 4'b0000;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs.
module sync_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;

    // Metastability-settling flop chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= {WIDTH{1'b0}};
            sync_r <= {WIDTH{1'b0}};
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/coin_acceptor.sv
// Coin validator front end: synchronizes and debounces the slot sensors and
// turns each insertion into a single coin strobe or a single reject strobe.
module coin_acceptor
    import vending_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 50000
) (
    input  logic       clk50m,
    input  logic       rst_n,
    input  logic [3:0] slot,
    input  logic       accept_en,
    output logic [3:0] coin,
    output logic       new_coin,
    output logic       reject,
    output logic       busy
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic [3:0]       slot_s;
    acc_state_t       state_r, state_n;
    logic [CNT_W-1:0] cnt_r, cnt_n;
    logic [3:0]       pat_r, pat_n;
    logic [3:0]       coin_r, coin_n;
    logic             new_coin_r, new_coin_n;
    logic             reject_r, reject_n;
    logic             busy_r, busy_n;

    sync_2ff #(.WIDTH(4)) u_sync (
        .clk   (clk50m),
        .rst_n (rst_n),
        .d     (slot),
        .q     (slot_s)
    );

    // Next-state and next-output logic; strobes are decided one edge early so they leave a flop.
    always_comb begin
        state_n    = state_r;
        cnt_n      = cnt_r;
        pat_n      = pat_r;
        coin_n     = coin_r;
        new_coin_n = 1'b0;
        reject_n   = 1'b0;
        case (state_r)
            ACC_IDLE: begin
                cnt_n = CNT_ZERO;
                if (slot_s != 4'b0000) begin
                    pat_n   = slot_s;
                    state_n = ACC_SETTLE;
                end else begin
                    state_n = ACC_IDLE;
                end
            end
            ACC_SETTLE: begin
                if (slot_s == 4'b0000) begin
                    cnt_n   = CNT_ZERO;
                    state_n = ACC_IDLE;
                end else if (slot_s != pat_r) begin
                    pat_n = slot_s;
                    cnt_n = CNT_ZERO;
                end else if (cnt_r == CNT_LAST) begin
                    cnt_n = CNT_ZERO;
                    if (is_one_hot(pat_r) && accept_en) begin
                        coin_n     = coin_code(pat_r);
                        new_coin_n = 1'b1;
                        state_n    = ACC_EMIT;
                    end else begin
                        reject_n = 1'b1;
                        state_n  = ACC_RELEASE;
                    end
                end else begin
                    cnt_n = cnt_r + CNT_ONE;
                end
            end
            ACC_EMIT: begin
                cnt_n   = CNT_ZERO;
                state_n = ACC_RELEASE;
            end
            ACC_RELEASE: begin
                // A held or bouncing coin keeps restarting the release window.
                if (slot_s != 4'b0000) begin
                    cnt_n = CNT_ZERO;
                end else if (cnt_r == CNT_LAST) begin
                    cnt_n   = CNT_ZERO;
                    state_n = ACC_IDLE;
                end else begin
                    cnt_n = cnt_r + CNT_ONE;
                end
            end
            default: begin
                cnt_n   = CNT_ZERO;
                state_n = ACC_IDLE;
            end
        endcase
        busy_n = (state_n != ACC_IDLE);
    end

    // State, counter and output registers.
    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ACC_IDLE;
            cnt_r      <= CNT_ZERO;
            pat_r      <= 4'b0000;
            coin_r     <= 4'b0000;
            new_coin_r <= 1'b0;
            reject_r   <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_n;
            cnt_r      <= cnt_n;
            pat_r      <= pat_n;
            coin_r     <= coin_n;
            new_coin_r <= new_coin_n;
            reject_r   <= reject_n;
            busy_r     <= busy_n;
        end
    end

    assign coin     = coin_r;
    assign new_coin = new_coin_r;
    assign reject   = reject_r;
    assign busy     = busy_r;

endmodule

// File: tb/tb_coin_acceptor.sv
// Bench for coin_acceptor: run-length reference model checked every cycle,
// directed scenarios with hand-derived latencies, then randomized insertions.
module tb_coin_acceptor;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] slot = 4'b0000;
    logic       accept_en = 1'b1;
    logic [3:0] coin;
    logic       new_coin;
    logic       reject;
    logic       busy;

    int errors = 0;
    int checks = 0;

    coin_acceptor #(.DEBOUNCE_CYC(D)) dut (
        .clk50m    (clk),
        .rst_n     (rst_n),
        .slot      (slot),
        .accept_en (accept_en),
        .coin      (coin),
        .new_coin  (new_coin),
        .reject    (reject),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference model: a settle needs D+1 identical nonzero samples while armed;
    // re-arming needs D consecutive zero samples after the decision.
    logic [3:0] m_s1 = 4'b0000, m_s2 = 4'b0000, m_cur, m_pat = 4'b0000;
    int         m_run = 0, m_zrun = 0;
    bit         m_armed = 1'b1, m_skip = 1'b0;
    logic [3:0] m_coin = 4'b0000;
    bit         m_new = 1'b0, m_rej = 1'b0, m_busy = 1'b0;

    function automatic logic [3:0] value_of(input logic [3:0] p);
        case (p)
            4'b0001: return 4'b0001;
            4'b0010: return 4'b0010;
            4'b0100: return 4'b0101;
            4'b1000: return 4'b1010;
            default: return 4'b1111;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 = 4'b0000; m_s2 = 4'b0000; m_pat = 4'b0000;
            m_run = 0; m_zrun = 0; m_armed = 1'b1; m_skip = 1'b0;
            m_coin = 4'b0000; m_new = 1'b0; m_rej = 1'b0; m_busy = 1'b0;
        end else begin
            m_cur = m_s2;
            m_s2  = m_s1;
            m_s1  = slot;
            m_new = 1'b0;
            m_rej = 1'b0;
            if (m_skip) begin
                m_skip = 1'b0;
                m_zrun = 0;
            end else if (!m_armed) begin
                m_zrun = (m_cur == 4'b0000) ? m_zrun + 1 : 0;
                if (m_zrun == D) begin
                    m_armed = 1'b1;
                    m_run   = 0;
                end
            end else begin
                if (m_cur == 4'b0000) begin
                    m_run = 0;
                end else if (m_run > 0 && m_cur == m_pat) begin
                    m_run = m_run + 1;
                end else begin
                    m_pat = m_cur;
                    m_run = 1;
                end
                if (m_run == D + 1) begin
                    if (value_of(m_pat) != 4'b1111 && accept_en) begin
                        m_new  = 1'b1;
                        m_coin = value_of(m_pat);
                        m_skip = 1'b1;
                    end else begin
                        m_rej = 1'b1;
                    end
                    m_armed = 1'b0;
                    m_zrun  = 0;
                    m_run   = 0;
                end
            end
            m_busy = !m_armed || (m_run != 0);
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        checks = checks + 4;
        if (coin !== m_coin) begin
            errors++; $display("FAIL coin: got %b expected %b at %0t", coin, m_coin, $time);
        end
        if (new_coin !== m_new) begin
            errors++; $display("FAIL new_coin: got %b expected %b at %0t", new_coin, m_new, $time);
        end
        if (reject !== m_rej) begin
            errors++; $display("FAIL reject: got %b expected %b at %0t", reject, m_rej, $time);
        end
        if (busy !== m_busy) begin
            errors++; $display("FAIL busy: got %b expected %b at %0t", busy, m_busy, $time);
        end
    end

    int first_new, first_rej, first_busy, first_idle, n_new, n_rej;

    task automatic clr_stats();
        first_new = 0; first_rej = 0; first_busy = 0; first_idle = 0;
        n_new = 0; n_rej = 0;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 1; i <= n; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (new_coin) begin n_new++; if (first_new == 0) first_new = i; end
            if (reject)   begin n_rej++; if (first_rej == 0) first_rej = i; end
            if (busy  && first_busy == 0) first_busy = i;
            if (!busy && first_idle == 0) first_idle = i;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_coin", int'(coin), 0);
        chk("reset_strobes", int'({new_coin, reject, busy}), 0);
        rst_n = 1'b1;
        run_cycles(3);

        // Clean 5-unit coin.
        clr_stats(); slot = 4'b0100; run_cycles(20);
        chk("c5_latency", first_new, 7);
        chk("c5_count", n_new, 1);
        chk("c5_busy_edge", first_busy, 3);
        chk("c5_code", int'(coin), 5);
        slot = 4'b0000; run_cycles(10);

        // Bouncing 1-unit coin, then stable.
        clr_stats();
        for (int i = 0; i < 12; i++) begin
            slot = (((i / 2) % 2) == 0) ? 4'b0001 : 4'b0000;
            run_cycles(1);
        end
        chk("bounce_quiet", n_new + n_rej, 0);
        clr_stats(); slot = 4'b0001; run_cycles(15);
        chk("c1_latency", first_new, 7);
        chk("c1_code", int'(coin), 1);
        slot = 4'b0000; run_cycles(10);

        // Two slots at once.
        clr_stats(); slot = 4'b0011; run_cycles(15);
        chk("multi_reject", n_rej, 1);
        chk("multi_no_coin", n_new, 0);
        chk("multi_coin_kept", int'(coin), 1);
        slot = 4'b0000; run_cycles(10);

        // 10-unit coin refused, then accepted.
        clr_stats(); slot = 4'b1000; accept_en = 1'b0; run_cycles(15);
        chk("refused_reject", n_rej, 1);
        chk("refused_no_coin", n_new, 0);
        slot = 4'b0000; accept_en = 1'b1; run_cycles(10);
        clr_stats(); slot = 4'b1000; run_cycles(15);
        chk("c10_count", n_new, 1);
        chk("c10_code", int'(coin), 10);
        slot = 4'b0000; run_cycles(10);

        // Held coin with a short low glitch.
        clr_stats(); slot = 4'b0100; run_cycles(50);
        slot = 4'b0000; run_cycles(2);
        slot = 4'b0100; run_cycles(20);
        chk("held_single", n_new, 1);
        chk("held_no_reject", n_rej, 0);
        clr_stats(); slot = 4'b0000; run_cycles(10);
        chk("release_edge", first_idle, 6);

        // Reset during settle with the coin still in the slot.
        clr_stats(); slot = 4'b0010; run_cycles(4);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            run_cycles(1);
            chk("in_reset_outputs", int'({coin, new_coin, reject, busy}), 0);
        end
        rst_n = 1'b1;
        clr_stats(); run_cycles(15);
        chk("post_reset_latency", first_new, 7);
        chk("post_reset_code", int'(coin), 2);
        slot = 4'b0000; run_cycles(10);

        // Randomized insertions, bounces and occasional resets.
        for (int s = 0; s < 300; s++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 4)      slot = 4'b0000;
            else if (r < 8) slot = 4'(4'b0001 << $urandom_range(0, 3));
            else            slot = 4'($urandom_range(1, 15));
            accept_en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 59) == 0) begin
                rst_n = 1'b0; run_cycles(2); rst_n = 1'b1;
            end
            run_cycles(int'($urandom_range(1, 12)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
